// File: rtl/ddr_cmd_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr_cmd_pkg                                                          |
// | Shared DDR command encodings, FSM states and bus widths.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ddr_cmd_pkg;

    localparam int c_BA_W  = 2;
    localparam int c_ROW_W = 13;
    localparam int c_COL_W = 10;

    // {ras, cas, we}, all active low on the pins
    localparam logic [2:0] c_CMD_NOP = 3'b111;
    localparam logic [2:0] c_CMD_ACT = 3'b011;
    localparam logic [2:0] c_CMD_RD  = 3'b101;
    localparam logic [2:0] c_CMD_WR  = 3'b100;
    localparam logic [2:0] c_CMD_PRE = 3'b010;
    localparam logic [2:0] c_CMD_REF = 3'b001;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ACT      = 4'd1,
        ST_WAIT_RCD = 4'd2,
        ST_RW       = 4'd3,
        ST_WAIT_PRE = 4'd4,
        ST_PRE      = 4'd5,
        ST_WAIT_RP  = 4'd6,
        ST_REF      = 4'd7,
        ST_WAIT_RFC = 4'd8
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_cmd_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr_cmd_sequencer_if                                                 |
// | Request handshake and issue strobes between requester and sequencer. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface ddr_cmd_sequencer_if;
    import ddr_cmd_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [c_BA_W-1:0]  req_ba;
    logic [c_ROW_W-1:0] req_row;
    logic [c_COL_W-1:0] req_col;
    logic               rd_issued;
    logic               wr_issued;

    modport master (
        output req_valid, req_we, req_ba, req_row, req_col,
        input  req_ready, rd_issued, wr_issued
    );

    modport slave (
        input  req_valid, req_we, req_ba, req_row, req_col,
        output req_ready, rd_issued, wr_issued
    );
endinterface
`default_nettype wire

// File: rtl/ddr_cmd_sequencer_refresh.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr_refresh_timer                                                    |
// | Free-running refresh interval counter with a sticky pending flag.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ddr_refresh_timer #(
    parameter int T_REFI = 780
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  ref_ack,
    output logic ref_pending
);
    localparam int c_CNT_W = (T_REFI > 1) ? $clog2(T_REFI) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(T_REFI - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_wrap;

    assign w_wrap = (r_cnt == c_LAST);

    // A wrap wins over the acknowledge so a refresh is never lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            ref_pending <= 1'b0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + c_CNT_W'(1);
            if (w_wrap) begin
                ref_pending <= 1'b1;
            end else if (ref_ack) begin
                ref_pending <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/ddr_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr_cmd_sequencer                                                    |
// | Closed-page ACT/RD-WR/PRE sequencer with periodic AUTO REFRESH.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ddr_cmd_sequencer
    import ddr_cmd_pkg::*;
#(
    parameter int T_RCD  = 3,
    parameter int T_RAS  = 6,
    parameter int T_WR   = 2,
    parameter int T_RP   = 3,
    parameter int T_RFC  = 10,
    parameter int T_REFI = 780
) (
    input  wire                     clk,
    input  wire                     rst,
    ddr_cmd_sequencer_if.slave      req,
    output logic                    ref_busy,
    output logic                    cke,
    output logic                    ras,
    output logic                    cas,
    output logic                    we,
    output logic [c_BA_W-1:0]       ba,
    output logic [c_ROW_W-1:0]      addr
);
    localparam int c_DLY_MAX = max2(T_RFC, T_RAS + T_WR + T_RCD);
    localparam int c_DLY_W   = $clog2(c_DLY_MAX + 1);

    // PRECHARGE cycle relative to ACTIVE at 1; the RW command sits at 1+T_RCD
    localparam int c_P_WR        = max2(1 + T_RAS, 2 + T_RCD + T_WR);
    localparam int c_P_RD        = max2(1 + T_RAS, 2 + T_RCD);
    localparam int c_PRE_WAIT_WR = c_P_WR - T_RCD - 2;
    localparam int c_PRE_WAIT_RD = c_P_RD - T_RCD - 2;

    state_t               r_state;
    logic [c_DLY_W-1:0]   r_cnt;
    logic                 r_cke;
    logic [2:0]           r_cmd;
    logic [c_BA_W-1:0]    r_cmd_ba;
    logic [c_ROW_W-1:0]   r_cmd_addr;
    logic                 r_ref_busy;
    logic                 r_rd_issued;
    logic                 r_wr_issued;
    logic                 r_req_we;
    logic [c_BA_W-1:0]    r_req_ba;
    logic [c_COL_W-1:0]   r_req_col;

    logic                 w_ref_pending;
    logic                 w_ref_ack;
    logic                 w_ready;
    logic [c_DLY_W-1:0]   w_pre_wait;

    ddr_refresh_timer #(
        .T_REFI (T_REFI)
    ) u_refresh (
        .clk         (clk),
        .rst         (rst),
        .ref_ack     (w_ref_ack),
        .ref_pending (w_ref_pending)
    );

    assign w_ref_ack  = (r_state == ST_REF);
    assign w_ready    = (r_state == ST_IDLE) && !w_ref_pending && r_cke;
    assign w_pre_wait = r_req_we ? c_DLY_W'(c_PRE_WAIT_WR) : c_DLY_W'(c_PRE_WAIT_RD);

    assign req.req_ready = w_ready;
    assign req.rd_issued = r_rd_issued;
    assign req.wr_issued = r_wr_issued;

    assign cke            = r_cke;
    assign {ras, cas, we} = r_cmd;
    assign ba             = r_cmd_ba;
    assign addr           = r_cmd_addr;
    assign ref_busy       = r_ref_busy;

    // The state names the command visible on the pins in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cke       <= 1'b0;
            r_cmd       <= c_CMD_NOP;
            r_cmd_ba    <= '0;
            r_cmd_addr  <= '0;
            r_ref_busy  <= 1'b0;
            r_rd_issued <= 1'b0;
            r_wr_issued <= 1'b0;
            r_req_we    <= 1'b0;
            r_req_ba    <= '0;
            r_req_col   <= '0;
        end else begin
            r_cke       <= 1'b1;
            r_cmd       <= c_CMD_NOP;
            r_rd_issued <= 1'b0;
            r_wr_issued <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ref_pending) begin
                        r_state    <= ST_REF;
                        r_cmd      <= c_CMD_REF;
                        r_cmd_ba   <= '0;
                        r_cmd_addr <= '0;
                        r_ref_busy <= 1'b1;
                    end else if (req.req_valid && w_ready) begin
                        r_state    <= ST_ACT;
                        r_cmd      <= c_CMD_ACT;
                        r_cmd_ba   <= req.req_ba;
                        r_cmd_addr <= req.req_row;
                        r_req_we   <= req.req_we;
                        r_req_ba   <= req.req_ba;
                        r_req_col  <= req.req_col;
                    end
                end
                ST_ACT: begin
                    r_state <= ST_WAIT_RCD;
                    r_cnt   <= c_DLY_W'(T_RCD - 2);
                end
                ST_WAIT_RCD: begin
                    if (r_cnt == '0) begin
                        r_state     <= ST_RW;
                        r_cmd       <= r_req_we ? c_CMD_WR : c_CMD_RD;
                        r_cmd_ba    <= r_req_ba;
                        r_cmd_addr  <= {{(c_ROW_W - c_COL_W){1'b0}}, r_req_col};
                        r_wr_issued <= r_req_we;
                        r_rd_issued <= !r_req_we;
                    end else begin
                        r_cnt <= r_cnt - c_DLY_W'(1);
                    end
                end
                ST_RW: begin
                    if (w_pre_wait == '0) begin
                        r_state    <= ST_PRE;
                        r_cmd      <= c_CMD_PRE;
                        r_cmd_ba   <= r_req_ba;
                        r_cmd_addr <= '0;
                    end else begin
                        r_state <= ST_WAIT_PRE;
                        r_cnt   <= w_pre_wait - c_DLY_W'(1);
                    end
                end
                ST_WAIT_PRE: begin
                    if (r_cnt == '0) begin
                        r_state    <= ST_PRE;
                        r_cmd      <= c_CMD_PRE;
                        r_cmd_ba   <= r_req_ba;
                        r_cmd_addr <= '0;
                    end else begin
                        r_cnt <= r_cnt - c_DLY_W'(1);
                    end
                end
                ST_PRE: begin
                    r_state <= ST_WAIT_RP;
                    r_cnt   <= c_DLY_W'(T_RP - 2);
                end
                ST_WAIT_RP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_DLY_W'(1);
                    end
                end
                ST_REF: begin
                    r_state <= ST_WAIT_RFC;
                    r_cnt   <= c_DLY_W'(T_RFC - 2);
                end
                ST_WAIT_RFC: begin
                    if (r_cnt == '0) begin
                        r_state    <= ST_IDLE;
                        r_ref_busy <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_DLY_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
